rs_bank: RTL and testbench

RS_BANK -- requirements
Module: rs_bank

---
 rtl/rs_pkg.sv | 30 +++
 rtl/rs_entry.sv | 112 +++++++++++
 rtl/rs_bank.sv | 151 +++++++++++++++
 tb/tb_rs_bank.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared reservation-station types: tag-0 sentinel, entry state, entry metadata and age compare.
package rs_pkg;

   // ROB tag 0 means "operand already available"
   localparam int unsigned TAG_NONE = 0;

   // Wide enough for up to 16 entries with one extra bit so modular age compare stays exact
   localparam int unsigned SEQ_W = 5;

   typedef enum logic [1:0] {
      StFree  = 2'd0,
      StWait  = 2'd1,
      StReady = 2'd2
   } entry_state_e;

   typedef logic [SEQ_W-1:0] seq_t;

   typedef struct packed {
      entry_state_e state;
      seq_t         seq;
   } entry_meta_t;

   // a was issued before b; live sequence numbers span less than half the ring
   function automatic logic seq_older(input seq_t a, input seq_t b);
      seq_t diff;
      diff = a - b;
      return diff[SEQ_W-1];
   endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: operand storage, CDB snoop and FREE/WAIT/READY state.
module rs_entry
   import rs_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned OP_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc,
   input  logic             free_en,
   input  seq_t             alloc_seq,
   input  logic [OP_W-1:0]  alloc_op,
   input  logic [TAG_W-1:0] alloc_dest,
   input  logic [XLEN-1:0]  alloc_vj,
   input  logic [XLEN-1:0]  alloc_vk,
   input  logic [TAG_W-1:0] alloc_qj,
   input  logic [TAG_W-1:0] alloc_qk,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_data,
   output entry_meta_t      meta,
   output logic [OP_W-1:0]  op,
   output logic [TAG_W-1:0] dest,
   output logic [XLEN-1:0]  vj,
   output logic [XLEN-1:0]  vk
);

   localparam logic [TAG_W-1:0] TagNone = TAG_W'(TAG_NONE);

   entry_meta_t      meta_q, meta_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [TAG_W-1:0] dest_q, dest_d;
   logic [XLEN-1:0]  vj_q, vj_d, vk_q, vk_d;
   logic [TAG_W-1:0] qj_q, qj_d, qk_q, qk_d;
   logic             cdb_live;

   assign cdb_live = cdb_valid && (cdb_tag != TagNone);

   // Next state: allocate (with issue-time bypass), release on dispatch, or snoop the CDB
   always_comb begin
      meta_d = meta_q;
      op_d   = op_q;
      dest_d = dest_q;
      vj_d   = vj_q;
      vk_d   = vk_q;
      qj_d   = qj_q;
      qk_d   = qk_q;
      if (alloc) begin
         meta_d.seq = alloc_seq;
         op_d       = alloc_op;
         dest_d     = alloc_dest;
         vj_d       = alloc_vj;
         vk_d       = alloc_vk;
         qj_d       = alloc_qj;
         qk_d       = alloc_qk;
         if (cdb_live && (alloc_qj == cdb_tag)) begin
            vj_d = cdb_data;
            qj_d = TagNone;
         end
         if (cdb_live && (alloc_qk == cdb_tag)) begin
            vk_d = cdb_data;
            qk_d = TagNone;
         end
         meta_d.state = ((qj_d == TagNone) && (qk_d == TagNone)) ? StReady : StWait;
      end else if (free_en) begin
         meta_d.state = StFree;
      end else if (meta_q.state == StWait) begin
         if (cdb_live && (qj_q == cdb_tag)) begin
            vj_d = cdb_data;
            qj_d = TagNone;
         end
         if (cdb_live && (qk_q == cdb_tag)) begin
            vk_d = cdb_data;
            qk_d = TagNone;
         end
         meta_d.state = ((qj_d == TagNone) && (qk_d == TagNone)) ? StReady : StWait;
      end
   end

   // Entry registers; reset clears everything, flush only frees the slot
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '{state: StFree, seq: '0};
         op_q   <= '0;
         dest_q <= '0;
         vj_q   <= '0;
         vk_q   <= '0;
         qj_q   <= '0;
         qk_q   <= '0;
      end else if (flush) begin
         meta_q.state <= StFree;
      end else begin
         meta_q <= meta_d;
         op_q   <= op_d;
         dest_q <= dest_d;
         vj_q   <= vj_d;
         vk_q   <= vk_d;
         qj_q   <= qj_d;
         qk_q   <= qk_d;
      end
   end

   assign meta = meta_q;
   assign op   = op_q;
   assign dest = dest_q;
   assign vj   = vj_q;
   assign vk   = vk_q;

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: allocation, oldest-ready dispatch select with hold lock, occupancy.
module rs_bank
   import rs_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 3,
   parameter int unsigned XLEN        = 32,
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned OP_W        = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic                               iss_valid,
   output logic                               iss_ready,
   input  logic [OP_W-1:0]                    iss_op,
   input  logic [TAG_W-1:0]                   iss_dest,
   input  logic [XLEN-1:0]                    iss_vj,
   input  logic [XLEN-1:0]                    iss_vk,
   input  logic [TAG_W-1:0]                   iss_qj,
   input  logic [TAG_W-1:0]                   iss_qk,
   input  logic                               cdb_valid,
   input  logic [TAG_W-1:0]                   cdb_tag,
   input  logic [XLEN-1:0]                    cdb_data,
   output logic                               disp_valid,
   input  logic                               disp_ready,
   output logic [OP_W-1:0]                    disp_op,
   output logic [XLEN-1:0]                    disp_a,
   output logic [XLEN-1:0]                    disp_b,
   output logic [TAG_W-1:0]                   disp_dest,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]   busy_count
);

   localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int unsigned CNT_W = $clog2(NUM_ENTRIES+1);

   entry_meta_t      ent_meta [NUM_ENTRIES];
   logic [OP_W-1:0]  ent_op   [NUM_ENTRIES];
   logic [TAG_W-1:0] ent_dest [NUM_ENTRIES];
   logic [XLEN-1:0]  ent_vj   [NUM_ENTRIES];
   logic [XLEN-1:0]  ent_vk   [NUM_ENTRIES];

   logic [NUM_ENTRIES-1:0] ent_free, ent_ready;
   logic [IDX_W-1:0]       alloc_idx, oldest_idx, sel_idx, lock_idx_q;
   logic                   any_ready, lock_q;
   logic                   iss_fire, disp_fire;
   seq_t                   seq_q;
   logic [CNT_W-1:0]       busy_cnt;

   for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
      assign ent_free[g]  = (ent_meta[g].state == StFree);
      assign ent_ready[g] = (ent_meta[g].state == StReady);

      rs_entry #(
         .XLEN  (XLEN),
         .TAG_W (TAG_W),
         .OP_W  (OP_W)
      ) u_entry (
         .clk        (clk),
         .rst        (rst),
         .flush      (flush),
         .alloc      (iss_fire && (alloc_idx == IDX_W'(g))),
         .free_en    (disp_fire && (sel_idx == IDX_W'(g))),
         .alloc_seq  (seq_q),
         .alloc_op   (iss_op),
         .alloc_dest (iss_dest),
         .alloc_vj   (iss_vj),
         .alloc_vk   (iss_vk),
         .alloc_qj   (iss_qj),
         .alloc_qk   (iss_qk),
         .cdb_valid  (cdb_valid),
         .cdb_tag    (cdb_tag),
         .cdb_data   (cdb_data),
         .meta       (ent_meta[g]),
         .op         (ent_op[g]),
         .dest       (ent_dest[g]),
         .vj         (ent_vj[g]),
         .vk         (ent_vk[g])
      );
   end

   // Lowest-index free entry receives the next issue
   always_comb begin
      alloc_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (ent_free[i]) alloc_idx = IDX_W'(i);
      end
   end

   // Oldest ready entry by modular sequence compare
   always_comb begin
      any_ready  = 1'b0;
      oldest_idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (ent_ready[i] && (!any_ready || seq_older(ent_meta[i].seq, ent_meta[oldest_idx].seq)))
         begin
            any_ready  = 1'b1;
            oldest_idx = IDX_W'(i);
         end
      end
   end

   // A stalled dispatch keeps presenting the entry it first offered
   assign sel_idx    = lock_q ? lock_idx_q : oldest_idx;
   assign disp_valid = lock_q || any_ready;
   assign iss_ready  = |ent_free;
   assign iss_fire   = iss_valid && iss_ready && !flush;
   assign disp_fire  = disp_valid && disp_ready && !flush;

   // Dispatch outputs forced to zero when nothing is offered
   always_comb begin
      disp_op   = '0;
      disp_a    = '0;
      disp_b    = '0;
      disp_dest = '0;
      if (disp_valid) begin
         disp_op   = ent_op[sel_idx];
         disp_a    = ent_vj[sel_idx];
         disp_b    = ent_vk[sel_idx];
         disp_dest = ent_dest[sel_idx];
      end
   end

   // Occupancy count
   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         busy_cnt = busy_cnt + {{(CNT_W-1){1'b0}}, !ent_free[i]};
      end
   end
   assign busy_count = busy_cnt;

   // Issue sequence counter and dispatch selection lock
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else if (flush) begin
         lock_q <= 1'b0;
      end else begin
         if (iss_fire) seq_q <= seq_q + 1'b1;
         if (disp_fire) begin
            lock_q <= 1'b0;
         end else if (disp_valid && !lock_q) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel_idx;
         end
      end
   end

endmodule

// File: tb/tb_rs_bank.sv
// Directed self-checking bench for rs_bank (3 entries, 32-bit data, 4-bit tags).
module tb_rs_bank;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        iss_valid, iss_ready;
   logic [3:0]  iss_op, iss_dest, iss_qj, iss_qk;
   logic [31:0] iss_vj, iss_vk;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        disp_valid, disp_ready;
   logic [3:0]  disp_op, disp_dest;
   logic [31:0] disp_a, disp_b;
   logic [1:0]  busy_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rs_bank #(
      .NUM_ENTRIES (3),
      .XLEN        (32),
      .TAG_W       (4),
      .OP_W        (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .iss_valid  (iss_valid),
      .iss_ready  (iss_ready),
      .iss_op     (iss_op),
      .iss_dest   (iss_dest),
      .iss_vj     (iss_vj),
      .iss_vk     (iss_vk),
      .iss_qj     (iss_qj),
      .iss_qk     (iss_qk),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .disp_valid (disp_valid),
      .disp_ready (disp_ready),
      .disp_op    (disp_op),
      .disp_a     (disp_a),
      .disp_b     (disp_b),
      .disp_dest  (disp_dest),
      .busy_count (busy_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] dest, input logic [31:0] vj,
                        input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk);
      iss_valid = 1'b1;
      iss_op    = op;
      iss_dest  = dest;
      iss_vj    = vj;
      iss_vk    = vk;
      iss_qj    = qj;
      iss_qk    = qk;
   endtask

   task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
      cdb_valid = 1'b1;
      cdb_tag   = tag;
      cdb_data  = data;
   endtask

   task automatic idle();
      iss_valid = 1'b0;
      iss_op    = '0;
      iss_dest  = '0;
      iss_vj    = '0;
      iss_vk    = '0;
      iss_qj    = '0;
      iss_qk    = '0;
      cdb_valid = 1'b0;
      cdb_tag   = '0;
      cdb_data  = '0;
   endtask

   initial begin
      idle();
      rst        = 1'b1;
      flush      = 1'b0;
      disp_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_iss_ready", 32'(iss_ready), 32'd1);
      check_eq("rst_disp_valid", 32'(disp_valid), 32'd0);
      check_eq("rst_busy", 32'(busy_count), 32'd0);
      check_eq("rst_disp_a", disp_a, 32'd0);
      check_eq("rst_disp_dest", 32'(disp_dest), 32'd0);

      // Simple ready issue, dispatched the cycle after
      issue(4'd1, 4'd1, 32'd5, 32'd7, 4'd0, 4'd0);
      disp_ready = 1'b1;
      check_eq("add_no_same_cycle", 32'(disp_valid), 32'd0);
      tick();
      idle();
      check_eq("add_valid", 32'(disp_valid), 32'd1);
      check_eq("add_a", disp_a, 32'd5);
      check_eq("add_b", disp_b, 32'd7);
      check_eq("add_dest", 32'(disp_dest), 32'd1);
      check_eq("add_op", 32'(disp_op), 32'd1);
      check_eq("add_busy", 32'(busy_count), 32'd1);
      tick();
      disp_ready = 1'b0;
      check_eq("add_freed", 32'(busy_count), 32'd0);
      check_eq("add_gone", 32'(disp_valid), 32'd0);
      check_eq("add_zero_a", disp_a, 32'd0);

      // Wake-up via CDB; tag 0 broadcast ignored
      issue(4'd2, 4'd2, 32'd0, 32'd4, 4'd3, 4'd0);
      tick();
      idle();
      check_eq("wake_wait", 32'(disp_valid), 32'd0);
      cdb(4'd0, 32'hff);
      tick();
      idle();
      check_eq("tag0_ignored", 32'(disp_valid), 32'd0);
      check_eq("tag0_busy", 32'(busy_count), 32'd1);
      cdb(4'd3, 32'h10);
      tick();
      idle();
      check_eq("wake_valid", 32'(disp_valid), 32'd1);
      check_eq("wake_a", disp_a, 32'h10);
      check_eq("wake_b", disp_b, 32'd4);
      disp_ready = 1'b1;
      tick();
      disp_ready = 1'b0;
      check_eq("wake_freed", 32'(busy_count), 32'd0);

      // Issue-time bypass
      issue(4'd3, 4'd3, 32'd0, 32'd1, 4'd2, 4'd0);
      cdb(4'd2, 32'd9);
      tick();
      idle();
      check_eq("byp_valid", 32'(disp_valid), 32'd1);
      check_eq("byp_a", disp_a, 32'd9);
      check_eq("byp_dest", 32'(disp_dest), 32'd3);
      disp_ready = 1'b1;
      tick();
      disp_ready = 1'b0;
      check_eq("byp_freed", 32'(busy_count), 32'd0);

      // Fill, full back-pressure, age ordering, concurrent issue+dispatch
      issue(4'd4, 4'd4, 32'd1, 32'd2, 4'd0, 4'd0);
      tick();
      issue(4'd5, 4'd5, 32'd0, 32'd3, 4'd7, 4'd0);
      tick();
      issue(4'd6, 4'd6, 32'd0, 32'd4, 4'd7, 4'd0);
      tick();
      idle();
      check_eq("full_iss_ready", 32'(iss_ready), 32'd0);
      check_eq("full_busy", 32'(busy_count), 32'd3);
      check_eq("full_dest", 32'(disp_dest), 32'd4);
      issue(4'd9, 4'd9, 32'd0, 32'd0, 4'd0, 4'd0);
      disp_ready = 1'b1;
      tick();
      idle();
      disp_ready = 1'b0;
      check_eq("full_reject_busy", 32'(busy_count), 32'd2);
      check_eq("full_reject_ready", 32'(iss_ready), 32'd1);
      check_eq("full_reject_nodisp", 32'(disp_valid), 32'd0);
      issue(4'd10, 4'd10, 32'd5, 32'd6, 4'd0, 4'd0);
      cdb(4'd7, 32'h20);
      tick();
      idle();
      check_eq("age_busy", 32'(busy_count), 32'd3);
      check_eq("age_dest", 32'(disp_dest), 32'd5);
      check_eq("age_a", disp_a, 32'h20);
      check_eq("age_b", disp_b, 32'd3);
      disp_ready = 1'b1;
      tick();
      check_eq("age2_busy", 32'(busy_count), 32'd2);
      check_eq("age2_dest", 32'(disp_dest), 32'd6);
      check_eq("age2_b", disp_b, 32'd4);
      issue(4'd11, 4'd11, 32'd0, 32'd0, 4'd8, 4'd0);
      tick();
      idle();
      check_eq("net_busy", 32'(busy_count), 32'd2);
      check_eq("net_dest", 32'(disp_dest), 32'd10);
      tick();
      disp_ready = 1'b0;
      check_eq("drain_busy", 32'(busy_count), 32'd1);
      check_eq("drain_nodisp", 32'(disp_valid), 32'd0);

      // Flush with waiting entries and a concurrent issue
      issue(4'd12, 4'd12, 32'd0, 32'd0, 4'd5, 4'd0);
      tick();
      idle();
      check_eq("pre_flush_busy", 32'(busy_count), 32'd2);
      flush = 1'b1;
      issue(4'd13, 4'd13, 32'd1, 32'd1, 4'd0, 4'd0);
      tick();
      flush = 1'b0;
      idle();
      check_eq("flush_busy", 32'(busy_count), 32'd0);
      check_eq("flush_disp", 32'(disp_valid), 32'd0);
      check_eq("flush_iss_ready", 32'(iss_ready), 32'd1);
      tick();
      check_eq("flush_no_store", 32'(disp_valid), 32'd0);

      // Selection lock: younger ready offered first, older woken later must wait
      issue(4'd1, 4'd1, 32'd0, 32'd2, 4'd9, 4'd0);
      tick();
      issue(4'd2, 4'd2, 32'd7, 32'd8, 4'd0, 4'd0);
      tick();
      idle();
      check_eq("lock_first_dest", 32'(disp_dest), 32'd2);
      cdb(4'd9, 32'd3);
      tick();
      idle();
      check_eq("lock_hold_dest", 32'(disp_dest), 32'd2);
      check_eq("lock_hold_a", disp_a, 32'd7);
      disp_ready = 1'b1;
      tick();
      check_eq("lock_next_dest", 32'(disp_dest), 32'd1);
      check_eq("lock_next_a", disp_a, 32'd3);
      check_eq("lock_next_b", disp_b, 32'd2);
      tick();
      disp_ready = 1'b0;
      check_eq("lock_drain_busy", 32'(busy_count), 32'd0);
      check_eq("lock_drain_disp", 32'(disp_valid), 32'd0);

      // Reset mid-operation beats issue and CDB
      issue(4'd3, 4'd3, 32'd1, 32'd1, 4'd0, 4'd0);
      tick();
      idle();
      check_eq("pre_rst_busy", 32'(busy_count), 32'd1);
      rst = 1'b1;
      issue(4'd4, 4'd4, 32'd1, 32'd1, 4'd0, 4'd0);
      cdb(4'd6, 32'd1);
      tick();
      rst = 1'b0;
      idle();
      check_eq("midrst_busy", 32'(busy_count), 32'd0);
      check_eq("midrst_disp", 32'(disp_valid), 32'd0);
      check_eq("midrst_iss_ready", 32'(iss_ready), 32'd1);
      check_eq("midrst_dest", 32'(disp_dest), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
